plusarg_timeout_monitor: RTL and testbench
==========================================

# plusarg_timeout_monitor

Progress watchdog that consumes the simulation plusarg enable flag (a plusarg presence bit) and a cycle limit. It counts cycles since the last forward-progress pulse and raises a sticky timeout indication when the limit is reached. It sits directly downstream of the plusarg flag/value readers in the test harness and drives the harness fail/finish logic.

## Interface

Parameters:
- `WIDTH`, default 32: counter and limit width in bits, legal range 2..64.

Ports:
- `clock`, input, 1: the single clock; all state updates on the rising edge.
- `reset_n`, input, 1: reset, asynchronous and active-low.
- `enable`, input, 1: monitor enable, normally the plusarg presence flag; quasi-static.
- `limit`, input, WIDTH: timeout in cycles. 0 means disabled.
- `progress`, input, 1: forward-progress strobe, one pulse per event.
- `clear`, input, 1: acknowledges and re-arms after expiry; also restarts the count when armed.
- `count`, output, WIDTH: cycles since the last progress event or arm.
- `expired`, output, 1: sticky timeout flag.
- `expired_pulse`, output, 1: high for exactly one cycle, on the first cycle `expired` is high.
- `armed`, output, 1: high while the FSM is in ARMED.

## Operation

States: IDLE, ARMED, EXPIRED. Encoding is free. All outputs are registered.

Reset (`reset_n`=0, asynchronous):
- State goes to IDLE; `count`=0, `expired`=0, `expired_pulse`=0, `armed`=0.
- Reset has effect mid-count or mid-expiry; no state survives it.

`go` = `enable` && (`limit` != 0).

IDLE:
- `count` is held at 0.
- If `go`, go to ARMED next cycle with `count`=0.

ARMED, evaluated in priority order each cycle:
1. If !`go`: go to IDLE, `count` <= 0.
2. Else if `progress` || `clear`: `count` <= 0, stay in ARMED. Progress always beats expiry on the same cycle.
3. Else if (`count`+1) >= `limit`: `count` <= `count`+1, go to EXPIRED, `expired` <= 1, `expired_pulse` <= 1.
4. Else: `count` <= `count`+1.

Arithmetic:
- `count`+1 is computed in WIDTH+1 bits, so the comparison is never corrupted by wrap.
- When `count` is all-ones it saturates and never wraps to 0.

EXPIRED:
- `count` is frozen and `expired` stays 1. `expired_pulse` returns to 0 after its single cycle.
- `progress` is ignored.
- If `clear` or !`go`: `expired` <= 0, `count` <= 0. Next state is ARMED if `go` && `clear`, else IDLE.
- `clear` and !`go` on the same cycle go to IDLE.

Limit changes mid-operation:
- The comparison always uses the current `limit`.
- Lowering `limit` to or below `count`+1 while ARMED expires on the next edge, absent progress.
- Raising `limit` simply extends the window.
- `limit` becoming 0 is treated as !`go`.

## Timing

- `armed` rises 1 cycle after `go` is first sampled high.
- With `limit`=L and no progress, arm edge at cycle A (`count`=0):
  - `count` equals k at cycle A+k.
  - `expired` and `expired_pulse` rise at cycle A+L, with `count`=L.
- `progress` sampled at edge E gives `count`=0 after E; counting resumes at 1 after E+1.
- `clear` in EXPIRED: `expired` falls and `armed` rises on the same edge. A new expiry needs L further cycles.
- L=1: expires 1 cycle after arming unless `progress` is sampled on that edge.
- There is no combinational path from inputs to outputs.

## Test plan

- **Reset and disabled:** `reset_n` asserted mid-ARMED with `count`=5 -> all outputs 0 immediately, with no clock edge. Hold `enable`=1, `limit`=0 for 50 cycles -> stays IDLE, `count`=0.
- **Basic expiry:** `enable`=1, `limit`=10, no progress -> `armed` 1 cycle after `enable`. `expired` and `expired_pulse` rise 10 cycles after arming with `count`=10. `expired_pulse` is 1 cycle wide; `expired` persists for 100 cycles.
- **Progress race:** `limit`=4, `progress` pulsed on the exact edge where `count`=3 -> no expiry, `count` returns to 0. Then no progress -> expiry 4 cycles later.
- **Clear and re-arm:** in EXPIRED, pulse `clear` with `enable`=1 -> next cycle `expired`=0, `armed`=1, `count`=0. Expiry recurs exactly `limit` cycles later, with a new 1-cycle `expired_pulse`.
- **Limit changes:** lower `limit` from 100 to 5 while `count`=20 -> EXPIRED on the next edge with `count`=21. Drop `enable` in EXPIRED -> IDLE and `expired`=0 next cycle.
- **Saturation:** `WIDTH`=4, `limit`=15, `progress` asserted every cycle -> `count` stays 0. Release `progress` -> expiry with `count`=15, with no wrap observed.

Source files
------------

// File: rtl/plusarg_timeout_monitor.sv
`default_nettype none
// ============================================================================
// Module      : plusarg_timeout_monitor
// Description : Progress watchdog for the test harness. Counts cycles since
//               the last forward-progress pulse (or since arming) and raises
//               a sticky timeout flag when the count reaches the limit.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clock          in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   enable         in   monitor enable (plusarg presence flag), quasi-static
//   limit          in   timeout in cycles, 0 disables the monitor
//   progress       in   forward-progress strobe, restarts the count
//   clear          in   acknowledge/re-arm after expiry, restart when armed
//   count          out  cycles since last progress event or arm
//   expired        out  sticky timeout flag
//   expired_pulse  out  one-cycle strobe on the first cycle of expired
//   armed          out  high while the monitor is actively counting
// Parameters:
//   WIDTH          counter/limit width in bits, legal range 2..64
// ============================================================================
module plusarg_timeout_monitor #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  input  logic             progress,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             expired,
  output logic             expired_pulse,
  output logic             armed
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_EXPIRED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             expired_q, expired_d;
  logic             pulse_q, pulse_d;
  logic             armed_q, armed_d;

  logic             go;
  logic [WIDTH:0]   count_inc;
  logic             count_max;
  logic [WIDTH-1:0] count_sat;

  assign go = enable && (limit != '0);

  // One extra bit keeps the limit comparison exact when count is all-ones.
  assign count_inc = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};
  assign count_max = &count_q;
  // The counter saturates rather than wrapping back to zero.
  assign count_sat = count_max ? count_q : count_inc[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pulse_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        if (go) begin
          state_d = ST_ARMED;
        end
      end

      ST_ARMED: begin
        if (!go) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (progress || clear) begin
          // Progress wins over an expiry that would land on the same edge.
          count_d = '0;
        end else if (count_inc >= {1'b0, limit}) begin
          count_d = count_sat;
          state_d = ST_EXPIRED;
          pulse_d = 1'b1;
        end else begin
          count_d = count_sat;
        end
      end

      ST_EXPIRED: begin
        // Count stays frozen at the expiry value; progress is ignored here.
        if (clear || !go) begin
          count_d = '0;
          state_d = (go && clear) ? ST_ARMED : ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase

    // Status flags are registered copies of the next state.
    expired_d = (state_d == ST_EXPIRED);
    armed_d   = (state_d == ST_ARMED);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      expired_q <= 1'b0;
      pulse_q   <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      expired_q <= expired_d;
      pulse_q   <= pulse_d;
      armed_q   <= armed_d;
    end
  end

  assign count         = count_q;
  assign expired       = expired_q;
  assign expired_pulse = pulse_q;
  assign armed         = armed_q;

endmodule
`default_nettype wire

// File: tb/tb_plusarg_timeout_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_plusarg_timeout_monitor
// Description : Self-checking bench for plusarg_timeout_monitor. Drives a
//               32-bit and a 4-bit instance with shared enable/progress/clear
//               and separate limits, compares every cycle against a
//               behavioural model, and adds directed scenario checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_plusarg_timeout_monitor;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic        progress;
  logic        clear;
  logic [31:0] limit;
  logic [31:0] count;
  logic        expired;
  logic        expired_pulse;
  logic        armed;
  logic [3:0]  limit4;
  logic [3:0]  count4;
  logic        expired4;
  logic        expired_pulse4;
  logic        armed4;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: index 0 = 32-bit instance, index 1 = 4-bit instance.
  longint m_cnt   [2];
  bit     m_arm   [2];
  bit     m_exp   [2];
  bit     m_pulse [2];

  plusarg_timeout_monitor #(.WIDTH(32)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .limit         (limit),
    .progress      (progress),
    .clear         (clear),
    .count         (count),
    .expired       (expired),
    .expired_pulse (expired_pulse),
    .armed         (armed)
  );

  plusarg_timeout_monitor #(.WIDTH(4)) dut4 (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .limit         (limit4),
    .progress      (progress),
    .clear         (clear),
    .count         (count4),
    .expired       (expired4),
    .expired_pulse (expired_pulse4),
    .armed         (armed4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_arm[i] = 0; m_exp[i] = 0; m_pulse[i] = 0;
    end
  endtask

  // One clock of the watchdog rules, written as plain arithmetic.
  task automatic model_step(input int i, input longint lim, input longint maxv);
    bit go;
    go = enable && (lim != 0);
    m_pulse[i] = 0;
    if (!go) begin
      m_arm[i] = 0; m_exp[i] = 0; m_cnt[i] = 0;
    end else if (m_exp[i]) begin
      if (clear) begin
        m_exp[i] = 0; m_arm[i] = 1; m_cnt[i] = 0;
      end
    end else if (!m_arm[i]) begin
      m_arm[i] = 1; m_cnt[i] = 0;
    end else if (progress || clear) begin
      m_cnt[i] = 0;
    end else begin
      if (m_cnt[i] + 1 >= lim) begin
        m_arm[i] = 0; m_exp[i] = 1; m_pulse[i] = 1;
      end
      m_cnt[i] = (m_cnt[i] + 1 > maxv) ? maxv : m_cnt[i] + 1;
    end
  endtask

  task automatic cmp_model();
    chk("m32_count",   {32'd0, count},    m_cnt[0]);
    chk("m32_expired", {63'd0, expired},  {63'd0, m_exp[0]});
    chk("m32_pulse",   {63'd0, expired_pulse}, {63'd0, m_pulse[0]});
    chk("m32_armed",   {63'd0, armed},    {63'd0, m_arm[0]});
    chk("m4_count",    {60'd0, count4},   m_cnt[1]);
    chk("m4_expired",  {63'd0, expired4}, {63'd0, m_exp[1]});
    chk("m4_pulse",    {63'd0, expired_pulse4}, {63'd0, m_pulse[1]});
    chk("m4_armed",    {63'd0, armed4},   {63'd0, m_arm[1]});
  endtask

  // Advance one clock; model follows the inputs sampled on the edge,
  // outputs are compared 1 time unit after the edge.
  task automatic cyc();
    @(posedge clock);
    if (!reset_n) begin
      model_reset();
    end else begin
      model_step(0, longint'(limit), 64'hFFFF_FFFF);
      model_step(1, longint'(limit4), 15);
    end
    #1;
    cmp_model();
  endtask

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b0;
    limit    = 32'd0;
    limit4   = 4'd0;
    progress = 1'b0;
    clear    = 1'b0;
    model_reset();
    cyc(); cyc();
    chk("rst_count",   {32'd0, count}, 64'd0);
    chk("rst_expired", {63'd0, expired}, 64'd0);
    chk("rst_armed",   {63'd0, armed}, 64'd0);
    reset_n = 1'b1;

    // Enable with a zero limit never arms.
    enable = 1'b1;
    repeat (50) cyc();
    chk("dis_count", {32'd0, count}, 64'd0);
    chk("dis_armed", {63'd0, armed}, 64'd0);

    // Basic expiry with limit 10.
    limit = 32'd10;
    cyc();
    chk("basic_armed", {63'd0, armed}, 64'd1);
    chk("basic_count0", {32'd0, count}, 64'd0);
    repeat (9) cyc();
    chk("basic_count9", {32'd0, count}, 64'd9);
    chk("basic_not_exp", {63'd0, expired}, 64'd0);
    cyc();
    chk("basic_exp", {63'd0, expired}, 64'd1);
    chk("basic_pulse", {63'd0, expired_pulse}, 64'd1);
    chk("basic_count10", {32'd0, count}, 64'd10);
    cyc();
    chk("basic_pulse_fall", {63'd0, expired_pulse}, 64'd0);
    repeat (99) cyc();
    chk("basic_sticky", {63'd0, expired}, 64'd1);
    chk("basic_frozen", {32'd0, count}, 64'd10);
    chk("basic_not_armed", {63'd0, armed}, 64'd0);

    // Clear and re-arm.
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("clr_exp", {63'd0, expired}, 64'd0);
    chk("clr_armed", {63'd0, armed}, 64'd1);
    chk("clr_count", {32'd0, count}, 64'd0);
    repeat (9) cyc();
    chk("clr_not_exp", {63'd0, expired}, 64'd0);
    cyc();
    chk("clr_reexp", {63'd0, expired}, 64'd1);
    chk("clr_repulse", {63'd0, expired_pulse}, 64'd1);

    // Progress on the edge that would otherwise expire.
    limit = 32'd4;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    repeat (3) cyc();
    chk("race_count3", {32'd0, count}, 64'd3);
    progress = 1'b1;
    cyc();
    progress = 1'b0;
    chk("race_count0", {32'd0, count}, 64'd0);
    chk("race_no_exp", {63'd0, expired}, 64'd0);
    chk("race_armed", {63'd0, armed}, 64'd1);
    repeat (3) cyc();
    chk("race_pre_exp", {63'd0, expired}, 64'd0);
    cyc();
    chk("race_exp", {63'd0, expired}, 64'd1);
    chk("race_count4", {32'd0, count}, 64'd4);

    // Lowering the limit below the running count.
    limit = 32'd100;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    repeat (20) cyc();
    chk("lim_count20", {32'd0, count}, 64'd20);
    limit = 32'd5;
    cyc();
    chk("lim_exp", {63'd0, expired}, 64'd1);
    chk("lim_count21", {32'd0, count}, 64'd21);
    chk("lim_pulse", {63'd0, expired_pulse}, 64'd1);
    enable = 1'b0;
    cyc();
    chk("lim_drop_exp", {63'd0, expired}, 64'd0);
    chk("lim_drop_armed", {63'd0, armed}, 64'd0);
    chk("lim_drop_count", {32'd0, count}, 64'd0);

    // Asynchronous reset mid-count.
    limit  = 32'd100;
    enable = 1'b1;
    cyc();
    repeat (5) cyc();
    chk("arst_pre_count", {32'd0, count}, 64'd5);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_count", {32'd0, count}, 64'd0);
    chk("arst_armed", {63'd0, armed}, 64'd0);
    chk("arst_exp", {63'd0, expired}, 64'd0);
    chk("arst_pulse", {63'd0, expired_pulse}, 64'd0);
    cyc(); cyc();
    reset_n = 1'b1;

    // Saturation on the 4-bit instance.
    limit    = 32'd0;
    limit4   = 4'd15;
    progress = 1'b1;
    repeat (20) cyc();
    chk("sat_hold0", {60'd0, count4}, 64'd0);
    chk("sat_armed", {63'd0, armed4}, 64'd1);
    progress = 1'b0;
    repeat (14) cyc();
    chk("sat_count14", {60'd0, count4}, 64'd14);
    chk("sat_not_exp", {63'd0, expired4}, 64'd0);
    cyc();
    chk("sat_exp", {63'd0, expired4}, 64'd1);
    chk("sat_count15", {60'd0, count4}, 64'd15);
    chk("sat_pulse", {63'd0, expired_pulse4}, 64'd1);
    repeat (5) cyc();
    chk("sat_no_wrap", {60'd0, count4}, 64'd15);

    // Randomised traffic against the model.
    limit  = 32'd6;
    limit4 = 4'd7;
    for (int n = 0; n < 800; n++) begin
      enable   = ($urandom_range(0, 24) != 0);
      progress = ($urandom_range(0, 7) == 0);
      clear    = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 15) == 0) limit  = 32'($urandom_range(0, 12));
      if ($urandom_range(0, 15) == 0) limit4 = 4'($urandom_range(0, 15));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
